// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - pixel SRAM bus between pixel controller and responder
//
// Signals:
//   address       controller -> responder  word address of request
//   w_data        controller -> responder  write data
//   read_enable   controller -> responder  read request (level)
//   write_enable  controller -> responder  write request (level)
//   r_data        responder -> controller  read data, held until next read completes
//   r_valid       responder -> controller  1-cycle strobe: r_data updated
//   w_done        responder -> controller  1-cycle strobe: write committed
//   busy          responder -> controller  access in progress
//   err           responder -> controller  1-cycle strobe: illegal request rejected
interface sram_responder_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 24
);
    logic [ADDR_BITS-1:0] address;
    logic [DATA_BITS-1:0] w_data;
    logic                 read_enable;
    logic                 write_enable;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 w_done;
    logic                 busy;
    logic                 err;

    modport master (
        output address, w_data, read_enable, write_enable,
        input  r_data, r_valid, w_done, busy, err
    );

    modport slave (
        input  address, w_data, read_enable, write_enable,
        output r_data, r_valid, w_done, busy, err
    );
endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - pixel SRAM bus responder with fixed wait states
//
// Services one read or write per LATENCY+2 cycles from an internal word array.
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset (memory contents are kept)
//   bus    sram_responder_if slave modport (request in, strobes/data out)
module sram_responder #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 24,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    sram_responder_if.slave   bus
);
    localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS+1)'(DEPTH);
    // Counter value on which WAIT hands over to DONE; unused when LATENCY==0
    localparam logic [3:0] LAST_CNT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    generate
        if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
            $error("sram_responder: LATENCY must be in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [IDX_BITS-1:0]   r_idx;
    logic [DATA_BITS-1:0]  r_wdata;
    logic                  r_is_write;
    logic [DATA_BITS-1:0]  r_rdata;
    logic                  r_rvalid;
    logic                  r_wdone;
    logic                  r_err;
    logic [DATA_BITS-1:0]  r_mem [DEPTH];

    logic                  w_any_en;
    logic                  w_legal;
    logic                  w_in_range;

    assign w_in_range = ({1'b0, bus.address} < DEPTH_L);
    assign w_any_en   = bus.read_enable | bus.write_enable;
    assign w_legal    = (bus.read_enable ^ bus.write_enable) & w_in_range;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_wdone    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_wdone  <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_en) begin
                        if (w_legal) begin
                            // Index taken from low bits only after the range check passed
                            r_idx      <= bus.address[IDX_BITS-1:0];
                            r_wdata    <= bus.w_data;
                            r_is_write <= bus.write_enable;
                            r_cnt      <= 4'd0;
                            r_state    <= (LATENCY == 0) ? S_DONE : S_WAIT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Strobes become visible together with the return to IDLE,
                    // so a held enable is accepted on the very next edge.
                    if (r_is_write) begin
                        r_wdone <= 1'b1;
                    end else begin
                        r_rdata  <= r_mem[r_idx];
                        r_rvalid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; a reset forces r_state to IDLE, which blocks the commit.
    always_ff @(posedge clk) begin
        if (r_state == S_DONE && r_is_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.r_data  = r_rdata;
    assign bus.r_valid = r_rvalid;
    assign bus.w_done  = r_wdone;
    assign bus.err     = r_err;
    assign bus.busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - scoreboard bench for sram_responder (LATENCY 2 and 0 builds)
module tb_sram_responder;
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    sram_responder_if #(.ADDR_BITS(16), .DATA_BITS(24)) bus_a ();
    sram_responder_if #(.ADDR_BITS(16), .DATA_BITS(24)) bus_b ();

    sram_responder #(.ADDR_BITS(16), .DATA_BITS(24), .DEPTH(1024), .LATENCY(2)) dut_a (
        .clk(clk), .n_rst(n_rst), .bus(bus_a.slave));
    sram_responder #(.ADDR_BITS(16), .DATA_BITS(24), .DEPTH(1024), .LATENCY(0)) dut_b (
        .clk(clk), .n_rst(n_rst), .bus(bus_b.slave));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 read, 1 write, 2 err
        logic [23:0] data;
        int          at;     // cycle count at which the strobe must be seen
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    logic [23:0] model_a [int];
    logic [23:0] model_b [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic mon_check(input int sel, input logic rv, input logic wd, input logic er,
                             input logic [23:0] rd);
        exp_t e;
        int   kind;
        if (!(rv || wd || er)) return;
        if ((sel == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe bus=%0d cycle=%0d rv=%0b wd=%0b err=%0b", sel, cyc, rv, wd, er);
            return;
        end
        e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
        kind = rv ? 0 : (wd ? 1 : 2);
        check($sformatf("strobe_kind bus=%0d", sel), kind, e.kind);
        check($sformatf("strobe_cycle bus=%0d", sel), cyc, e.at);
        if (e.kind == 0) check($sformatf("r_data bus=%0d", sel), rd, e.data);
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            mon_check(0, bus_a.r_valid, bus_a.w_done, bus_a.err, bus_a.r_data);
            mon_check(1, bus_b.r_valid, bus_b.w_done, bus_b.err, bus_b.r_data);
        end
    end

    task automatic drive(input int sel, input logic re, input logic we,
                         input logic [15:0] addr, input logic [23:0] data);
        if (sel == 0) begin
            bus_a.read_enable = re; bus_a.write_enable = we;
            bus_a.address = addr;   bus_a.w_data = data;
        end else begin
            bus_b.read_enable = re; bus_b.write_enable = we;
            bus_b.address = addr;   bus_b.w_data = data;
        end
    endtask

    // Pushes the expected response; the model tracks committed memory contents.
    task automatic expect_op(input int sel, input int kind, input logic [15:0] addr,
                             input logic [23:0] data, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        e.data = data;
        if (kind == 1) begin
            if (sel == 0) model_a[int'(addr)] = data; else model_b[int'(addr)] = data;
        end else if (kind == 0) begin
            e.data = (sel == 0) ? model_a[int'(addr)] : model_b[int'(addr)];
        end
        if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
    endtask

    task automatic access(input int sel, input logic we, input logic [15:0] addr,
                          input logic [23:0] data);
        int lat;
        lat = (sel == 0) ? 2 : 0;
        @(posedge clk); #1;
        drive(sel, !we, we, addr, data);
        expect_op(sel, we ? 1 : 0, addr, data, cyc + lat + 2);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 16'h0, 24'h0);
        repeat (lat + 2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 24'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 24'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_r_data", bus_a.r_data, 24'h0);
        check("reset_r_valid", bus_a.r_valid, 1'b0);
        check("reset_w_done", bus_a.w_done, 1'b0);
        check("reset_busy", bus_a.busy, 1'b0);
        check("reset_err", bus_a.err, 1'b0);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);

        // Write 0xA1B2C3 @0x0010: busy for 3 cycles, w_done only after T0+3
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 16'h0010, 24'hA1B2C3);
        expect_op(0, 1, 16'h0010, 24'hA1B2C3, cyc + 4);
        @(posedge clk); #1;
        check("wr_busy_t0", bus_a.busy, 1'b1);
        check("wr_wdone_t0", bus_a.w_done, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 16'h0, 24'h0);
        check("wr_busy_t1", bus_a.busy, 1'b1);
        @(posedge clk); #1;
        check("wr_busy_t2", bus_a.busy, 1'b1);
        check("wr_wdone_t2", bus_a.w_done, 1'b0);
        @(posedge clk); #1;
        check("wr_busy_t3", bus_a.busy, 1'b0);
        check("wr_wdone_t3", bus_a.w_done, 1'b1);
        @(negedge clk);

        // Read back, then r_data must hold after r_valid drops
        access(0, 1'b0, 16'h0010, 24'h0);
        repeat (3) @(posedge clk); #1;
        check("rd_hold_r_data", bus_a.r_data, 24'hA1B2C3);
        check("rd_hold_r_valid", bus_a.r_valid, 1'b0);

        // Reset mid-WAIT aborts a write to 0x0010
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 16'h0010, 24'h555555);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 16'h0, 24'h0);
        check("abort_busy_before", bus_a.busy, 1'b1);
        n_rst = 1'b0;
        #1;
        check("abort_busy", bus_a.busy, 1'b0);
        check("abort_r_data", bus_a.r_data, 24'h0);
        check("abort_r_valid", bus_a.r_valid, 1'b0);
        check("abort_w_done", bus_a.w_done, 1'b0);
        repeat (2) @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (5) @(posedge clk);
        access(0, 1'b0, 16'h0010, 24'h0);

        // Pre-load 0..3, then held read_enable stepping the address per accept
        access(0, 1'b1, 16'h0000, 24'h0F0F0F);
        access(0, 1'b1, 16'h0001, 24'h123ABC);
        access(0, 1'b1, 16'h0002, 24'hFEDCBA);
        access(0, 1'b1, 16'h0003, 24'h00FF00);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 1'b0, 16'(i), 24'h0);
            expect_op(0, 0, 16'(i), 24'h0, cyc + 4);
            @(posedge clk); #1;
            drive(0, 1'b1, 1'b0, 16'h02AA, 24'h0);
            repeat (3) @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, 16'h0, 24'h0);
        repeat (3) @(posedge clk);

        // Illegal requests: both enables, then out-of-range read and write
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 16'h0010, 24'h777777);
        expect_op(0, 2, 16'h0, 24'h0, cyc + 1);
        @(posedge clk); #1;
        check("illegal_both_busy", bus_a.busy, 1'b0);
        drive(0, 1'b1, 1'b0, 16'h0400, 24'h0);
        expect_op(0, 2, 16'h0, 24'h0, cyc + 1);
        @(posedge clk); #1;
        check("illegal_rd_busy", bus_a.busy, 1'b0);
        drive(0, 1'b0, 1'b1, 16'h0400, 24'h999999);
        expect_op(0, 2, 16'h0, 24'h0, cyc + 1);
        @(posedge clk); #1;
        check("illegal_wr_busy", bus_a.busy, 1'b0);
        drive(0, 1'b0, 1'b0, 16'h0, 24'h0);
        repeat (2) @(posedge clk); #1;
        check("illegal_r_data_kept", bus_a.r_data, 24'h00FF00);
        access(0, 1'b0, 16'h0000, 24'h0);
        access(0, 1'b0, 16'h0010, 24'h0);

        // LATENCY=0 build: write/read top word, then held read every 2 cycles
        access(1, 1'b1, 16'h03FF, 24'h123456);
        access(1, 1'b0, 16'h03FF, 24'h0);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 16'h03FF, 24'h0);
        expect_op(1, 0, 16'h03FF, 24'h0, cyc + 2);
        expect_op(1, 0, 16'h03FF, 24'h0, cyc + 4);
        expect_op(1, 0, 16'h03FF, 24'h0, cyc + 6);
        repeat (6) @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 16'h0, 24'h0);
        repeat (5) @(posedge clk);
        @(negedge clk);

        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
